xgmii_rx_deframer: RTL and testbench



---
 rtl/xgmii_pkg.sv | 45 ++++
 rtl/xgmii_term_find.sv | 31 +++
 rtl/xgmii_rx_deframer.sv | 229 ++++++++++++++++++++++
 tb/tb_xgmii_rx_deframer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/xgmii_pkg.sv
// rtl/xgmii_pkg.sv - shared XGMII constants, state encoding and helpers
package xgmii_pkg;

  localparam int LANE_W = 8;
  localparam int LANES  = 8;

  localparam logic [7:0] CH_IDLE  = 8'h07;
  localparam logic [7:0] CH_START = 8'hFB;
  localparam logic [7:0] CH_TERM  = 8'hFD;
  localparam logic [7:0] CH_ERROR = 8'hFE;
  localparam logic [7:0] CH_PRE   = 8'h55;
  localparam logic [7:0] CH_SFD   = 8'hD5;

  // A frame still running at this many bytes is cut off and dropped
  localparam logic [15:0] FORCE_LEN = 16'd4096;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_DROP
  } state_t;

  // /S/ in lane 0, six preamble bytes, SFD in lane 7
  function automatic logic is_start(input logic [7:0] rxc, input logic [63:0] rxd);
    return (rxc == 8'h01) && (rxd[7:0] == CH_START) &&
           (rxd[55:8] == {6{CH_PRE}}) && (rxd[63:56] == CH_SFD);
  endfunction

  function automatic logic is_idle(input logic [7:0] rxc, input logic [63:0] rxd);
    return (rxc == 8'hFF) && (rxd == {LANES{CH_IDLE}});
  endfunction

  // Lanes below n valid
  function automatic logic [7:0] keep_mask(input logic [2:0] n);
    return (8'h01 << n) - 8'h01;
  endfunction

  // Zero every lane whose keep bit is clear
  function automatic logic [63:0] mask_bytes(input logic [63:0] d, input logic [7:0] keep);
    logic [63:0] m;
    for (int k = 0; k < LANES; k++) m[k*LANE_W +: LANE_W] = keep[k] ? d[k*LANE_W +: LANE_W] : 8'h00;
    return m;
  endfunction

endpackage

// File: rtl/xgmii_term_find.sv
// rtl/xgmii_term_find.sv - locate the /T/ lane in an XGMII word
module xgmii_term_find
  import xgmii_pkg::*;
(
  input  logic [7:0]  rxc,
  input  logic [63:0] rxd,
  output logic [2:0]  term_lane,
  output logic        term_found,
  output logic        illegal
);

  logic       any_ctl;
  logic [7:0] ctl_byte;

  // Lowest control lane decides: FD there is a terminate, anything else is an error
  always_comb begin
    any_ctl   = 1'b0;
    term_lane = 3'd0;
    ctl_byte  = 8'h00;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (rxc[i]) begin
        any_ctl   = 1'b1;
        term_lane = i[2:0];
        ctl_byte  = rxd[i*LANE_W +: LANE_W];
      end
    end
    term_found = any_ctl && (ctl_byte == CH_TERM);
    illegal    = any_ctl && (ctl_byte != CH_TERM);
  end

endmodule

// File: rtl/xgmii_rx_deframer.sv
// rtl/xgmii_rx_deframer.sv - XGMII receive deframer with frame counters
module xgmii_rx_deframer
  import xgmii_pkg::*;
#(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518
) (
  input  logic        gmii_clk,
  input  logic        sys_rst_n,
  input  logic [7:0]  gmii_rxc,
  input  logic [63:0] gmii_rxd,
  output logic        out_valid,
  output logic [63:0] out_data,
  output logic [7:0]  out_keep,
  output logic        out_sop,
  output logic        out_eop,
  output logic        out_err,
  output logic [15:0] out_len,
  output logic [15:0] good_cnt,
  output logic [15:0] bad_cnt
);

  logic [7:0]  rxc_q;
  logic [63:0] rxd_q;
  state_t      state, state_nx;
  logic [63:0] hold_data, hold_data_nx;
  logic        hold_valid, hold_valid_nx;
  logic        first, first_nx;
  logic        part_pend, part_pend_nx;
  logic [7:0]  part_keep, part_keep_nx;
  logic [15:0] len, len_nx;
  logic [2:0]  term_lane;
  logic        term_found, illegal;
  logic        emit, e_sop, e_eop, e_err;
  logic [7:0]  e_keep;
  logic [15:0] e_len;
  logic        good_inc, bad_eop, bad_noout;

  xgmii_term_find u_term_find (
    .rxc        (rxc_q),
    .rxd        (rxd_q),
    .term_lane  (term_lane),
    .term_found (term_found),
    .illegal    (illegal)
  );

  function automatic logic len_bad(input logic [15:0] l);
    return (l < 16'(MIN_LEN)) || (l > 16'(MAX_LEN));
  endfunction

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  // Input register stage
  always_ff @(posedge gmii_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rxc_q <= 8'h00;
      rxd_q <= 64'h0;
    end else begin
      rxc_q <= gmii_rxc;
      rxd_q <= gmii_rxd;
    end
  end

  // State, hold register, length and counters
  always_ff @(posedge gmii_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= ST_IDLE;
      hold_data  <= 64'h0;
      hold_valid <= 1'b0;
      first      <= 1'b0;
      part_pend  <= 1'b0;
      part_keep  <= 8'h00;
      len        <= 16'h0;
      good_cnt   <= 16'h0;
      bad_cnt    <= 16'h0;
    end else begin
      state      <= state_nx;
      hold_data  <= hold_data_nx;
      hold_valid <= hold_valid_nx;
      first      <= first_nx;
      part_pend  <= part_pend_nx;
      part_keep  <= part_keep_nx;
      len        <= len_nx;
      good_cnt   <= good_cnt + 16'(good_inc);
      bad_cnt    <= bad_cnt + 16'(bad_eop) + 16'(bad_noout);
    end
  end

  // Next state and emission of the held word; the word in rxd_q decides what happens to it
  always_comb begin
    state_nx      = state;
    hold_data_nx  = hold_data;
    hold_valid_nx = hold_valid;
    first_nx      = first;
    part_pend_nx  = 1'b0;
    part_keep_nx  = part_keep;
    len_nx        = len;
    emit          = 1'b0;
    e_sop         = 1'b0;
    e_eop         = 1'b0;
    e_err         = 1'b0;
    e_keep        = 8'h00;
    e_len         = 16'h0;
    bad_noout     = 1'b0;

    unique case (state)
      ST_IDLE: begin
        // Trailing partial word goes out regardless of what arrives now
        if (part_pend) begin
          emit          = 1'b1;
          e_sop         = first;
          e_eop         = 1'b1;
          e_keep        = part_keep;
          e_len         = len;
          e_err         = len_bad(len);
          hold_valid_nx = 1'b0;
          first_nx      = 1'b0;
        end
        if (is_start(rxc_q, rxd_q)) begin
          state_nx      = ST_DATA;
          len_nx        = 16'h0;
          first_nx      = 1'b1;
          hold_valid_nx = 1'b0;
        end else if ((rxc_q[0] && rxd_q[7:0] == CH_START) ||
                     (rxc_q[4] && rxd_q[39:32] == CH_START)) begin
          bad_noout = 1'b1;
          state_nx  = ST_DROP;
        end
      end

      ST_DATA: begin
        if (len >= FORCE_LEN) begin
          emit          = hold_valid;
          e_sop         = first;
          e_eop         = 1'b1;
          e_err         = 1'b1;
          e_keep        = 8'hFF;
          e_len         = len;
          bad_noout     = !hold_valid;
          hold_valid_nx = 1'b0;
          first_nx      = 1'b0;
          state_nx      = ST_DROP;
        end else if (rxc_q == 8'h00) begin
          if (hold_valid) begin
            emit     = 1'b1;
            e_sop    = first;
            e_keep   = 8'hFF;
            first_nx = 1'b0;
          end
          hold_data_nx  = rxd_q;
          hold_valid_nx = 1'b1;
          len_nx        = sat_add(len, 16'd8);
        end else if (term_found) begin
          if (term_lane == 3'd0) begin
            if (hold_valid) begin
              emit   = 1'b1;
              e_sop  = first;
              e_eop  = 1'b1;
              e_keep = 8'hFF;
              e_len  = len;
              e_err  = len_bad(len);
            end else begin
              bad_noout = 1'b1;
            end
            hold_valid_nx = 1'b0;
            first_nx      = 1'b0;
          end else begin
            if (hold_valid) begin
              emit     = 1'b1;
              e_sop    = first;
              e_keep   = 8'hFF;
              first_nx = 1'b0;
            end
            hold_data_nx  = mask_bytes(rxd_q, keep_mask(term_lane));
            hold_valid_nx = 1'b1;
            part_pend_nx  = 1'b1;
            part_keep_nx  = keep_mask(term_lane);
            len_nx        = sat_add(len, {13'h0, term_lane});
          end
          state_nx = ST_IDLE;
        end else begin
          // Error word: close the frame as bad, restart only on a clean start word
          emit          = hold_valid;
          e_sop         = first;
          e_eop         = 1'b1;
          e_err         = 1'b1;
          e_keep        = 8'hFF;
          e_len         = len;
          bad_noout     = !hold_valid;
          hold_valid_nx = 1'b0;
          first_nx      = 1'b0;
          if (is_start(rxc_q, rxd_q)) begin
            state_nx = ST_DATA;
            len_nx   = 16'h0;
            first_nx = 1'b1;
          end else begin
            state_nx = ST_DROP;
          end
        end
      end

      ST_DROP: begin
        if (is_idle(rxc_q, rxd_q)) state_nx = ST_IDLE;
      end

      default: state_nx = ST_IDLE;
    endcase

    good_inc = emit && e_eop && !e_err;
    bad_eop  = emit && e_eop && e_err;
  end

  assign out_valid = emit;
  assign out_data  = emit ? hold_data : 64'h0;
  assign out_keep  = emit ? e_keep : 8'h00;
  assign out_sop   = emit && e_sop;
  assign out_eop   = emit && e_eop;
  assign out_err   = emit && e_eop && e_err;
  assign out_len   = (emit && e_eop) ? e_len : 16'h0;

  // illegal is implied by !term_found on a non-data word; kept for visibility
  logic unused_illegal;
  assign unused_illegal = illegal;

endmodule

// File: tb/tb_xgmii_rx_deframer.sv
// tb/tb_xgmii_rx_deframer.sv - scoreboard bench for xgmii_rx_deframer
module tb_xgmii_rx_deframer;

  localparam logic [63:0] START_WORD = 64'hD555_5555_5555_55FB;
  localparam logic [63:0] IDLE_WORD  = 64'h0707_0707_0707_0707;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        sop;
    logic        eop;
    logic        err;
    logic [15:0] len;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rxc = 8'hFF;
  logic [63:0] rxd = IDLE_WORD;
  logic        out_valid, out_sop, out_eop, out_err;
  logic [63:0] out_data;
  logic [7:0]  out_keep;
  logic [15:0] out_len, good_cnt, bad_cnt;

  beat_t q[$];
  int checks = 0;
  int failures = 0;
  int exp_good = 0;
  int exp_bad = 0;

  xgmii_rx_deframer dut (
    .gmii_clk  (clk),
    .sys_rst_n (rst_n),
    .gmii_rxc  (rxc),
    .gmii_rxd  (rxd),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_keep  (out_keep),
    .out_sop   (out_sop),
    .out_eop   (out_eop),
    .out_err   (out_err),
    .out_len   (out_len),
    .good_cnt  (good_cnt),
    .bad_cnt   (bad_cnt)
  );

  always #5 clk = ~clk;

  // Monitor: every output beat must match the head of the expected queue
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_beat actual data=%h keep=%h sop=%b eop=%b required none", out_data, out_keep, out_sop, out_eop);
      end else begin
        beat_t e;
        logic [63:0] m;
        e = q.pop_front();
        for (int k = 0; k < 8; k++) m[k*8 +: 8] = e.keep[k] ? 8'hFF : 8'h00;
        if (((out_data & m) !== (e.data & m)) || out_keep !== e.keep || out_sop !== e.sop ||
            out_eop !== e.eop || (e.eop && (out_err !== e.err || out_len !== e.len))) begin
          failures++;
          $display("FAIL beat actual data=%h keep=%h sop=%b eop=%b err=%b len=%0d required data=%h keep=%h sop=%b eop=%b err=%b len=%0d",
                   out_data & m, out_keep, out_sop, out_eop, out_err, out_len,
                   e.data & m, e.keep, e.sop, e.eop, e.err, e.len);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic send_word(input logic [7:0] c, input logic [63:0] d);
    @(posedge clk);
    #1;
    rxc = c;
    rxd = d;
  endtask

  function automatic logic [63:0] pat_word(input int seed, input int idx);
    logic [63:0] w;
    for (int k = 0; k < 8; k++) w[k*8 +: 8] = 8'(seed + idx * 8 + k);
    return w;
  endfunction

  function automatic beat_t mk(input logic [63:0] d, input logic [7:0] kp, input logic s,
                               input logic e, input logic er, input int l);
    beat_t b;
    b.data = d; b.keep = kp; b.sop = s; b.eop = e; b.err = er; b.len = 16'(l);
    return b;
  endfunction

  // Start word, n payload bytes, /T/ right after the last byte
  task automatic send_frame(input int n, input int seed);
    int nfull = n / 8;
    int r = n % 8;
    logic err = (n < 64) || (n > 1518);
    logic [63:0] w;
    logic [7:0]  c;
    send_word(8'h01, START_WORD);
    for (int i = 0; i < nfull; i++) begin
      w = pat_word(seed, i);
      q.push_back(mk(w, 8'hFF, i == 0, (r == 0) && (i == nfull - 1), err, n));
      send_word(8'h00, w);
    end
    w = pat_word(seed, nfull);
    c = 8'hFF;
    for (int k = r; k < 8; k++) w[k*8 +: 8] = CH(k == r);
    for (int k = 0; k < r; k++) c[k] = 1'b0;
    if (r > 0) q.push_back(mk(w, (8'h01 << r) - 8'h01, nfull == 0, 1'b1, err, n));
    send_word(c, w);
    if (n == 0 || err) exp_bad++;
    else exp_good++;
  endtask

  function automatic logic [7:0] CH(input logic term);
    return term ? 8'hFD : 8'h07;
  endfunction

  // Feed idles until every expected beat has appeared, then compare counters
  task automatic drain(input string name);
    for (int c = 0; c < 200 && q.size() != 0; c++) send_word(8'hFF, IDLE_WORD);
    repeat (4) send_word(8'hFF, IDLE_WORD);
    check({name, "_drained"}, 64'(q.size()), 64'd0);
    check({name, "_good_cnt"}, 64'(good_cnt), 64'(exp_good));
    check({name, "_bad_cnt"}, 64'(bad_cnt), 64'(exp_bad));
  endtask

  initial begin
    logic [63:0] w;
    #3;
    check("reset_outputs", {out_valid, out_sop, out_eop, out_err, out_keep, out_len, good_cnt, bad_cnt},
          64'h0);
    check("reset_data", out_data, 64'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) send_word(8'hFF, IDLE_WORD);
    check("idle_no_output", {63'h0, out_valid}, 64'h0);

    send_frame(64, 8'h10);
    drain("f64");
    send_frame(67, 8'h20);
    drain("f67");

    // Error control char in lane 6 of the fourth data word
    send_word(8'h01, START_WORD);
    for (int i = 0; i < 3; i++) begin
      q.push_back(mk(pat_word(8'h40, i), 8'hFF, i == 0, i == 2, i == 2, 24));
      send_word(8'h00, pat_word(8'h40, i));
    end
    w = pat_word(8'h40, 3);
    w[55:48] = 8'hFE;
    send_word(8'h40, w);
    send_word(8'h00, pat_word(8'h40, 4));
    send_word(8'h00, pat_word(8'h40, 5));
    exp_bad++;
    drain("fe_lane6");
    send_frame(64, 8'h50);
    drain("after_fe");

    // Bad SFD, then a good frame
    w = START_WORD;
    w[63:56] = 8'h55;
    send_word(8'h01, w);
    exp_bad++;
    drain("bad_sfd");
    send_frame(72, 8'h60);
    drain("after_sfd");

    // FB in lane 4
    send_word(8'h10, 64'h0707_07FB_0000_0000);
    exp_bad++;
    drain("fb_lane4");

    // Start immediately followed by terminate
    send_frame(0, 0);
    drain("empty");

    send_frame(40, 8'h70);
    drain("f40");
    send_frame(1600, 8'h80);
    drain("f1600");
    send_frame(7, 8'h90);
    drain("f7");

    // Back to back with a single idle word between
    send_frame(64, 8'hA0);
    send_word(8'hFF, IDLE_WORD);
    send_frame(72, 8'hB0);
    drain("b2b");

    // Reset in the middle of a frame
    send_word(8'h01, START_WORD);
    q.push_back(mk(pat_word(8'hC0, 0), 8'hFF, 1'b1, 1'b0, 1'b0, 0));
    for (int i = 0; i < 4; i++) send_word(8'h00, pat_word(8'hC0, i));
    #1;
    check("valid_before_reset", {63'h0, out_valid}, 64'h1);
    rst_n = 1'b0;
    #1;
    check("valid_in_reset", {63'h0, out_valid}, 64'h0);
    check("cnt_in_reset", {32'h0, good_cnt, bad_cnt}, 64'h0);
    exp_good = 0;
    exp_bad = 0;
    rxc = 8'hFF;
    rxd = IDLE_WORD;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("reset_queue_empty", 64'(q.size()), 64'd0);
    q.delete();
    repeat (2) send_word(8'hFF, IDLE_WORD);
    send_frame(64, 8'hD0);
    drain("post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
